// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sits directly downstream of the 4x4 array multiplier. It takes unsigned
// products over a valid/ready handshake, sums LEN of them into one ACC_W-bit
// dot-product result, offers that result on a valid/ready output and then
// starts the next sum.
//
// Parameters
//   PROD_W  width of incoming product                (default 8)
//   ACC_W   accumulator/result width, ACC_W >= PROD_W (default 16)
//   LEN     products per result, LEN >= 1             (default 4)
//
// Ports
//   clk         in   1       clock, all state updates on the rising edge
//   rst         in   1       synchronous active-high reset
//   prod_valid  in   1       upstream product valid
//   prod_ready  out  1       product accepted this cycle when valid
//   prod        in   PROD_W  product value, unsigned
//   clear       in   1       synchronous flush of the partial sum (ACCUM only)
//   acc_valid   out  1       result valid
//   acc_ready   in   1       downstream accepts result
//   acc_out     out  ACC_W   accumulated result, unsigned, registered
//   ovf         out  1       sticky overflow flag for the current result
//
// Build option
//   ACC_SAT_EN  when defined, acc_out clamps to all-ones on overflow;
//               otherwise it wraps modulo 2^ACC_W. ovf sets in both cases.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              clear,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  localparam int unsigned CntW = $clog2(LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LEN - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("product_accumulator: ACC_W must be >= PROD_W");
  end
  if (LEN < 1) begin : g_len_check
    $error("product_accumulator: LEN must be >= 1");
  end

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              beat;
  logic              last_beat;
  logic [ACC_W:0]    sum;
  logic              carry;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: begin
        if (last_beat) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (acc_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // prod_ready is a function of state, clear and rst only, so there is no
  // combinational path from prod/prod_valid to any output.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    unique case (state_q)
      StAccum: prod_ready = !rst && !clear;
      StHold:  acc_valid  = 1'b1;
      default: begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
      end
    endcase
  end

  assign beat      = prod_valid && prod_ready;
  assign last_beat = beat && (cnt_q == CntLast);

  // One extra bit catches the carry-out that drives ovf.
  assign sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = sum[ACC_W];

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (state_q)
      StAccum: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (beat) begin
`ifdef ACC_SAT_EN
          // Once clamped, acc_q is all-ones: any non-zero product carries
          // again and a zero product leaves it unchanged, so it stays clamped.
          acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | carry;
          cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
        end
      end
      StHold: begin
        // Result and flag are frozen until the handshake completes.
        if (acc_ready) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;

`ifndef SYNTHESIS
  // A pending result must not move while downstream stalls.
  a_hold_stable : assert property (@(posedge clk)
    (!rst && acc_valid && !acc_ready) |=> (acc_valid && $stable(acc_out) && $stable(ovf)));

  a_no_ready_in_hold : assert property (@(posedge clk) acc_valid |-> !prod_ready);

  a_no_ready_in_rst : assert property (@(posedge clk) rst |-> !prod_ready);

  a_rst_state : assert property (@(posedge clk)
    rst |=> (!acc_valid && (acc_out == '0) && !ovf));
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances: A (LEN=4, ACC_W=16) for the
// normal data path and B (LEN=8, ACC_W=10) to reach overflow quickly.
// A transaction-level model counts accepted products as plain integers and
// queues expected results; a negedge monitor compares what the DUT presents.
module tb_product_accumulator;

  localparam int unsigned ProdW = 8;
  localparam int unsigned LenA  = 4;
  localparam int unsigned AccWA = 16;
  localparam int unsigned LenB  = 8;
  localparam int unsigned AccWB = 10;
  localparam int Lens[2]   = '{LenA, LenB};
  localparam int Widths[2] = '{AccWA, AccWB};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Driven inputs, index 0 = instance A, index 1 = instance B.
  logic [1:0]       rst;
  logic [1:0]       prod_valid;
  logic [1:0]       clear;
  logic [1:0]       acc_ready;
  logic [ProdW-1:0] prod [2];

  // DUT outputs.
  logic             prod_ready_a, prod_ready_b;
  logic             acc_valid_a, acc_valid_b;
  logic             ovf_a, ovf_b;
  logic [AccWA-1:0] acc_out_a;
  logic [AccWB-1:0] acc_out_b;

  logic [1:0]  prod_ready_v, acc_valid_v, ovf_v;
  logic [63:0] acc_x [2];

  always_comb begin
    prod_ready_v = {prod_ready_b, prod_ready_a};
    acc_valid_v  = {acc_valid_b, acc_valid_a};
    ovf_v        = {ovf_b, ovf_a};
    acc_x[0]     = {48'b0, acc_out_a};
    acc_x[1]     = {54'b0, acc_out_b};
  end

  product_accumulator #(.PROD_W(ProdW), .ACC_W(AccWA), .LEN(LenA)) u_dut_a (
    .clk        (clk),
    .rst        (rst[0]),
    .prod_valid (prod_valid[0]),
    .prod_ready (prod_ready_a),
    .prod       (prod[0]),
    .clear      (clear[0]),
    .acc_valid  (acc_valid_a),
    .acc_ready  (acc_ready[0]),
    .acc_out    (acc_out_a),
    .ovf        (ovf_a)
  );

  product_accumulator #(.PROD_W(ProdW), .ACC_W(AccWB), .LEN(LenB)) u_dut_b (
    .clk        (clk),
    .rst        (rst[1]),
    .prod_valid (prod_valid[1]),
    .prod_ready (prod_ready_b),
    .prod       (prod[1]),
    .clear      (clear[1]),
    .acc_valid  (acc_valid_b),
    .acc_ready  (acc_ready[1]),
    .acc_out    (acc_out_b),
    .ovf        (ovf_b)
  );

  int checks = 0;
  int errors = 0;
  int results [2] = '{0, 0};

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  exp_t   exp_q [2][$];
  bit     m_hold  [2] = '{1'b0, 1'b0};
  int     m_cnt   [2] = '{0, 0};
  longint m_total [2] = '{0, 0};

  // Expected register value for a true (unbounded) running total.
  function automatic longint model_acc(longint total, int w);
    longint lim;
    lim = longint'(1) << w;
    if (total < lim) return total;
`ifdef ACC_SAT_EN
    return lim - 1;
`else
    return total % lim;
`endif
  endfunction

  function automatic bit model_ovf(longint total, int w);
    return total >= (longint'(1) << w);
  endfunction

  task automatic check(string name, int i, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %0d required %0d", name, i, $time, act, exp);
    end
  endtask

  // Reference model: advances on each clock from the inputs the DUT saw.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint t;
      exp_t   e;
      if (rst[i]) begin
        m_hold[i]  <= 1'b0;
        m_cnt[i]   <= 0;
        m_total[i] <= 0;
        exp_q[i].delete();
      end else if (m_hold[i]) begin
        if (acc_ready[i]) begin
          m_hold[i]  <= 1'b0;
          m_total[i] <= 0;
        end
      end else if (clear[i]) begin
        m_cnt[i]   <= 0;
        m_total[i] <= 0;
      end else if (prod_valid[i]) begin
        t = m_total[i] + longint'(prod[i]);
        m_total[i] <= t;
        if (m_cnt[i] == Lens[i] - 1) begin
          e.acc = model_acc(t, Widths[i]);
          e.ovf = model_ovf(t, Widths[i]);
          exp_q[i].push_back(e);
          m_hold[i] <= 1'b1;
          m_cnt[i]  <= 0;
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  // Monitor: compares everything the DUT presents, pops on result handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check("prod_ready", i, 64'(prod_ready_v[i]),
            64'(!rst[i] && !m_hold[i] && !clear[i]));
      check("acc_valid", i, 64'(acc_valid_v[i]), 64'(m_hold[i]));
      if (m_hold[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL result_unexpected[%0d] @%0t: got acc_out %0d required no result",
                   i, $time, acc_x[i]);
        end else begin
          check("result_acc", i, acc_x[i], 64'(exp_q[i][0].acc));
          check("result_ovf", i, 64'(ovf_v[i]), 64'(exp_q[i][0].ovf));
          if (acc_ready[i] && !rst[i]) begin
            void'(exp_q[i].pop_front());
            results[i]++;
          end
        end
      end else begin
        check("partial_acc", i, acc_x[i], 64'(model_acc(m_total[i], Widths[i])));
        check("partial_ovf", i, 64'(ovf_v[i]), 64'(model_ovf(m_total[i], Widths[i])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and keep it valid until it is taken (bounded).
  task automatic beat(int i, int v);
    bit ok;
    ok = 1'b0;
    prod[i]       = ProdW'(v);
    prod_valid[i] = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = prod_ready_v[i];
      tick();
    end
    prod_valid[i] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat_timeout[%0d] @%0t: got no acceptance required acceptance of %0d",
               i, $time, v);
    end
  endtask

  // Wait until every queued result has been handed out (bounded).
  task automatic drain(int i);
    for (int k = 0; k < 40 && exp_q[i].size() != 0; k++) tick();
    check("drain_empty", i, 64'(exp_q[i].size()), 64'd0);
  endtask

  initial begin
    rst        = 2'b11;
    prod_valid = 2'b00;
    clear      = 2'b00;
    acc_ready  = 2'b11;
    prod[0]    = '0;
    prod[1]    = '0;
    tick();
    tick();
    rst = 2'b00;
    tick();

    // Basic sum: 225+1+42+0 = 268.
    beat(0, 225); beat(0, 1); beat(0, 42); beat(0, 0);
    drain(0);

    // Downstream stall with a product waiting; 9 must start the next sum.
    acc_ready[0] = 1'b0;
    beat(0, 225); beat(0, 1); beat(0, 42); beat(0, 0);
    prod[0]       = 8'd9;
    prod_valid[0] = 1'b1;
    clear[0]      = 1'b1;  // ignored while holding
    repeat (5) tick();
    clear[0]     = 1'b0;
    acc_ready[0] = 1'b1;
    beat(0, 9); beat(0, 1); beat(0, 1); beat(0, 1);
    drain(0);

    // Back-to-back beats, two results of 8.
    repeat (8) beat(0, 2);
    drain(0);

    // clear with a simultaneous product: the 7 is not taken.
    beat(0, 225); beat(0, 225);
    clear[0]      = 1'b1;
    prod[0]       = 8'd7;
    prod_valid[0] = 1'b1;
    tick();
    clear[0]      = 1'b0;
    prod_valid[0] = 1'b0;
    repeat (4) beat(0, 1);
    drain(0);

    // Overflow on the narrow instance: 8 x 225 = 1800.
    repeat (8) beat(1, 225);
    drain(1);

    // Reset mid-sum, then a fresh result of 12.
    beat(0, 100); beat(0, 100); beat(0, 100);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    tick();
    repeat (4) beat(0, 3);
    drain(0);

    // Reset while a result is held.
    acc_ready[0] = 1'b0;
    repeat (4) beat(0, 5);
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0]       = 1'b0;
    acc_ready[0] = 1'b1;
    tick();

    // Randomised traffic on both instances.
    repeat (2000) begin
      for (int i = 0; i < 2; i++) begin
        prod[i]       = ProdW'($urandom_range(0, 255));
        prod_valid[i] = ($urandom_range(0, 3) != 0);
        acc_ready[i]  = ($urandom_range(0, 3) != 0);
        clear[i]      = ($urandom_range(0, 15) == 0);
        rst[i]        = ($urandom_range(0, 63) == 0);
      end
      tick();
    end
    rst        = 2'b00;
    clear      = 2'b00;
    prod_valid = 2'b00;
    acc_ready  = 2'b11;
    tick();
    drain(0);
    drain(1);

    checks++;
    if (results[0] < 7 || results[1] < 2) begin
      errors++;
      $display("FAIL result_count: got %0d/%0d required at least 7/2", results[0], results[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of stimulus required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
